key_filter: RTL and testbench

//  Receive-side conditioner for a raw mechanical push-button input.

---
 rtl/key_filter.sv | 120 ++++++++++++
 tb/tb_key_filter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_filter.sv
// Push-button conditioner: 2-FF synchroniser, bounce filter FSM, press/release
// pulses, debounced level and an LED that toggles on every confirmed press.
module key_filter #(
    parameter int unsigned CNT_MAX = 999_999,
    parameter int unsigned CNT_W   = 20
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_release,
    output logic key_state,
    output logic led_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS_F = 2'd1,
        DOWN    = 2'd2,
        REL_F   = 2'd3
    } state_t;

    // The sample that enters a filter state is the first stable sample, so the
    // count is complete one step early: CNT_MAX+1 stable samples in total.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       sync_q;
    logic             key_s;
    logic             cnt_done;
    logic             press_hit;
    logic             rel_hit;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_in};
        end
    end

    assign key_s    = sync_q[1];
    assign cnt_done = (cnt == CNT_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counter is zero on every transition and only advances while the
    // sampled level matches the level being confirmed.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        press_hit = 1'b0;
        rel_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nxt = PRESS_F;
                end
            end
            PRESS_F: begin
                if (key_s) begin
                    state_nxt = IDLE;
                end else if (cnt_done) begin
                    state_nxt = DOWN;
                    press_hit = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DOWN: begin
                if (key_s) begin
                    state_nxt = REL_F;
                end
            end
            REL_F: begin
                if (!key_s) begin
                    state_nxt = DOWN;
                end else if (cnt_done) begin
                    state_nxt = IDLE;
                    rel_hit   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            key_flag    <= 1'b0;
            key_release <= 1'b0;
            key_state   <= 1'b1;
            led_out     <= 1'b0;
        end else begin
            key_flag    <= press_hit;
            key_release <= rel_hit;
            if (press_hit) begin
                key_state <= 1'b0;
                led_out   <= ~led_out;
            end else if (rel_hit) begin
                key_state <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter with a short filter; pulse events are scoreboarded
// against the cycle at which they are due.
module tb_key_filter;

    localparam int CNT_MAX = 9;
    localparam int CNT_W   = 4;
    localparam int LAT     = CNT_MAX + 3;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic key_in;
    logic key_flag;
    logic key_release;
    logic key_state;
    logic led_out;

    logic [31:0] cyc = '0;
    int          total = 0;
    int          bad   = 0;
    logic [32:0] exp_q[$];
    logic        exp_led;

    key_filter #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key_in      (key_in),
        .key_flag    (key_flag),
        .key_release (key_release),
        .key_state   (key_state),
        .led_out     (led_out)
    );

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Each pulse must match the oldest pending event in type and cycle.
    always @(negedge sys_clk) begin
        logic [32:0] e;
        if (key_flag === 1'b1 || key_release === 1'b1) begin
            total++;
            if (key_flag === 1'b1 && key_release === 1'b1) begin
                bad++;
                $display("FAIL both_pulses cycle=%0d flag=%b release=%b required one at a time", cyc, key_flag, key_release);
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse cycle=%0d release=%b required none", cyc, key_release);
            end else begin
                e = exp_q.pop_front();
                if ({key_release, cyc} !== e) begin
                    bad++;
                    $display("FAIL pulse_event got release=%b cycle=%0d required release=%b cycle=%0d",
                             key_release, cyc, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_pulse(input logic is_rel, input logic [31:0] at);
        exp_q.push_back({is_rel, at});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        key_in  = 1'b1;
        exp_led = 1'b0;
        #1;
        total++; if (key_flag !== 1'b0) begin bad++; $display("FAIL rst_flag got=%b required=0", key_flag); end
        total++; if (key_release !== 1'b0) begin bad++; $display("FAIL rst_release got=%b required=0", key_release); end
        total++; if (key_state !== 1'b1) begin bad++; $display("FAIL rst_state got=%b required=1", key_state); end
        total++; if (led_out !== 1'b0) begin bad++; $display("FAIL rst_led got=%b required=0", led_out); end
        tick(3);
        sys_rst = 1'b0;
        tick(3);
    endtask

    task automatic test_press();
        logic [31:0] d;
        d = cyc;
        key_in = 1'b0;
        expect_pulse(1'b0, d + LAT);
        exp_led = ~exp_led;
        tick(LAT - 1);
        total++; if (key_state !== 1'b1) begin bad++; $display("FAIL press_early_state got=%b required=1", key_state); end
        tick(1);
        total++; if (key_state !== 1'b0) begin bad++; $display("FAIL press_state got=%b required=0", key_state); end
        total++; if (led_out !== exp_led) begin bad++; $display("FAIL press_led got=%b required=%b", led_out, exp_led); end
        tick(40 - LAT);
        total++; if (key_state !== 1'b0) begin bad++; $display("FAIL press_hold_state got=%b required=0", key_state); end
        #2;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL press_drain pending=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_release();
        logic [31:0] d;
        d = cyc;
        key_in = 1'b1;
        expect_pulse(1'b1, d + LAT);
        tick(LAT - 1);
        total++; if (key_state !== 1'b0) begin bad++; $display("FAIL rel_early_state got=%b required=0", key_state); end
        tick(1);
        total++; if (key_state !== 1'b1) begin bad++; $display("FAIL rel_state got=%b required=1", key_state); end
        total++; if (led_out !== exp_led) begin bad++; $display("FAIL rel_led got=%b required=%b", led_out, exp_led); end
        tick(20 - LAT);
        #2;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rel_drain pending=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_bounce();
        int   run;
        int   stray;
        logic v;
        run   = 0;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            v = ($urandom_range(0, 1) != 0);
            if (run >= CNT_MAX - 1) v = 1'b1;
            run = v ? 0 : run + 1;
            key_in = v;
            tick(1);
            if (key_state !== 1'b1) stray++;
        end
        key_in = 1'b1;
        tick(25);
        total++; if (stray != 0) begin bad++; $display("FAIL bounce_state_dips got=%0d required=0", stray); end
        total++; if (key_state !== 1'b1) begin bad++; $display("FAIL bounce_state got=%b required=1", key_state); end
        total++; if (led_out !== exp_led) begin bad++; $display("FAIL bounce_led got=%b required=%b", led_out, exp_led); end
    endtask

    task automatic test_boundary();
        logic [31:0] d;
        key_in = 1'b0;
        tick(CNT_MAX);
        key_in = 1'b1;
        tick(20);
        total++; if (key_state !== 1'b1) begin bad++; $display("FAIL short_state got=%b required=1", key_state); end
        total++; if (led_out !== exp_led) begin bad++; $display("FAIL short_led got=%b required=%b", led_out, exp_led); end
        d = cyc;
        key_in = 1'b0;
        expect_pulse(1'b0, d + LAT);
        exp_led = ~exp_led;
        tick(CNT_MAX + 1);
        d = cyc;
        key_in = 1'b1;
        expect_pulse(1'b1, d + LAT);
        tick(LAT + 5);
        total++; if (key_state !== 1'b1) begin bad++; $display("FAIL exact_state got=%b required=1", key_state); end
        total++; if (led_out !== exp_led) begin bad++; $display("FAIL exact_led got=%b required=%b", led_out, exp_led); end
        #2;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL exact_drain pending=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        d = cyc;
        key_in = 1'b0;
        expect_pulse(1'b0, d + LAT);
        exp_led = ~exp_led;
        tick(LAT + 3);
        d = cyc;
        key_in = 1'b1;
        expect_pulse(1'b1, d + LAT);
        tick(LAT + 3);
        total++; if (led_out !== exp_led) begin bad++; $display("FAIL mid_pre_led got=%b required=%b", led_out, exp_led); end
        key_in = 1'b0;
        tick(7);
        sys_rst = 1'b1;
        exp_led = 1'b0;
        #1;
        total++; if (key_flag !== 1'b0) begin bad++; $display("FAIL mid_rst_flag got=%b required=0", key_flag); end
        total++; if (key_release !== 1'b0) begin bad++; $display("FAIL mid_rst_release got=%b required=0", key_release); end
        total++; if (key_state !== 1'b1) begin bad++; $display("FAIL mid_rst_state got=%b required=1", key_state); end
        total++; if (led_out !== 1'b0) begin bad++; $display("FAIL mid_rst_led got=%b required=0", led_out); end
        tick(2);
        sys_rst = 1'b0;
        d = cyc;
        expect_pulse(1'b0, d + LAT);
        exp_led = ~exp_led;
        tick(LAT - 1);
        total++; if (key_state !== 1'b1) begin bad++; $display("FAIL mid_early_state got=%b required=1", key_state); end
        tick(1);
        total++; if (key_state !== 1'b0) begin bad++; $display("FAIL mid_state got=%b required=0", key_state); end
        total++; if (led_out !== exp_led) begin bad++; $display("FAIL mid_led got=%b required=%b", led_out, exp_led); end
        d = cyc;
        key_in = 1'b1;
        expect_pulse(1'b1, d + LAT);
        tick(LAT + 3);
        #2;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_drain pending=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_two_cycles();
        logic [31:0] d;
        key_in  = 1'b1;
        sys_rst = 1'b1;
        exp_led = 1'b0;
        tick(2);
        sys_rst = 1'b0;
        tick(2);
        for (int n = 0; n < 2; n++) begin
            d = cyc;
            key_in = 1'b0;
            expect_pulse(1'b0, d + LAT);
            exp_led = ~exp_led;
            tick(LAT + 4);
            total++; if (key_state !== 1'b0) begin bad++; $display("FAIL two_press_state n=%0d got=%b required=0", n, key_state); end
            total++; if (led_out !== exp_led) begin bad++; $display("FAIL two_press_led n=%0d got=%b required=%b", n, led_out, exp_led); end
            d = cyc;
            key_in = 1'b1;
            expect_pulse(1'b1, d + LAT);
            tick(LAT + 4);
            total++; if (key_state !== 1'b1) begin bad++; $display("FAIL two_rel_state n=%0d got=%b required=1", n, key_state); end
        end
        total++; if (led_out !== 1'b0) begin bad++; $display("FAIL two_final_led got=%b required=0", led_out); end
        #2;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL two_drain pending=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_boundary();
        test_reset_mid();
        test_two_cycles();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
